// File: rtl/key_candidate_scanner.sv
// Walks the candidate-key mux select, registers each candidate and compares it
// against a latched target under a mask, accumulating first index, count and bitmap.
module key_candidate_scanner #(
    parameter int WIDTH    = 128,
    parameter int NUM_CAND = 16,
    parameter int SEL_W    = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [WIDTH-1:0]    target,
    input  logic [WIDTH-1:0]    mask,
    output logic [SEL_W-1:0]    sel,
    input  logic [WIDTH-1:0]    cand,
    output logic                busy,
    output logic                done,
    output logic                match_found,
    output logic [SEL_W-1:0]    match_idx,
    output logic [SEL_W:0]      match_count,
    output logic [NUM_CAND-1:0] match_bitmap
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [WIDTH-1:0]    target_q, target_d;
    logic [WIDTH-1:0]    mask_q, mask_d;
    logic [WIDTH-1:0]    cand_q, cand_d;
    logic [SEL_W-1:0]    cap_idx_q, cap_idx_d;
    logic                cap_valid_q, cap_valid_d;
    logic                found_q, found_d;
    logic [SEL_W-1:0]    idx_q, idx_d;
    logic [SEL_W:0]      count_q, count_d;
    logic [NUM_CAND-1:0] bitmap_q, bitmap_d;
    logic                match;

    assign match = ~|((cand_q ^ target_q) & mask_q);

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        target_d    = target_q;
        mask_d      = mask_q;
        cand_d      = cand_q;
        cap_idx_d   = cap_idx_q;
        cap_valid_d = 1'b0;
        found_d     = found_q;
        idx_d       = idx_q;
        count_d     = count_q;
        bitmap_d    = bitmap_q;

        // Compare stage trails capture by one cycle
        if (cap_valid_q && match) begin
            bitmap_d[cap_idx_q] = 1'b1;
            count_d             = count_q + 1'b1;
            if (!found_q) begin
                found_d = 1'b1;
                idx_d   = cap_idx_q;
            end
        end

        unique case (state_q)
            S_IDLE: begin
                sel_d  = '0;
                busy_d = 1'b0;
                if (start) begin
                    target_d = target;
                    mask_d   = mask;
                    found_d  = 1'b0;
                    idx_d    = '0;
                    count_d  = '0;
                    bitmap_d = '0;
                    sel_d    = '0;
                    busy_d   = 1'b1;
                    state_d  = S_SCAN;
                end
            end
            S_SCAN: begin
                cand_d      = cand;
                cap_idx_d   = sel_q;
                cap_valid_d = 1'b1;
                if (sel_q == SEL_W'(NUM_CAND - 1)) begin
                    sel_d   = '0;
                    state_d = S_DONE;
                end else begin
                    sel_d = sel_q + 1'b1;
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                sel_d   = '0;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            sel_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            target_q    <= '0;
            mask_q      <= '0;
            cand_q      <= '0;
            cap_idx_q   <= '0;
            cap_valid_q <= 1'b0;
            found_q     <= 1'b0;
            idx_q       <= '0;
            count_q     <= '0;
            bitmap_q    <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            target_q    <= target_d;
            mask_q      <= mask_d;
            cand_q      <= cand_d;
            cap_idx_q   <= cap_idx_d;
            cap_valid_q <= cap_valid_d;
            found_q     <= found_d;
            idx_q       <= idx_d;
            count_q     <= count_d;
            bitmap_q    <= bitmap_d;
        end
    end

    assign sel          = sel_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign match_found  = found_q;
    assign match_idx    = idx_q;
    assign match_count  = count_q;
    assign match_bitmap = bitmap_q;

endmodule

// File: tb/tb_key_candidate_scanner.sv
// Directed bench for key_candidate_scanner with a queue scoreboard of
// expected scan results checked whenever done pulses.
module tb_key_candidate_scanner;

    localparam int WIDTH    = 128;
    localparam int NUM_CAND = 16;
    localparam int SEL_W    = 4;

    logic                clk;
    logic                rst_n;
    logic                start;
    logic [WIDTH-1:0]    target;
    logic [WIDTH-1:0]    mask;
    logic [SEL_W-1:0]    sel;
    logic [WIDTH-1:0]    cand;
    logic                busy;
    logic                done;
    logic                match_found;
    logic [SEL_W-1:0]    match_idx;
    logic [SEL_W:0]      match_count;
    logic [NUM_CAND-1:0] match_bitmap;

    logic [WIDTH-1:0] cand_tbl [NUM_CAND];

    typedef struct {
        logic                found;
        logic [SEL_W-1:0]    idx;
        logic [SEL_W:0]      cnt;
        logic [NUM_CAND-1:0] bmp;
        int                  cyc;
    } exp_t;

    exp_t sbq[$];
    exp_t last_exp;
    int   cyc;
    int   checks;
    int   errors;

    localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};

    key_candidate_scanner #(
        .WIDTH(WIDTH), .NUM_CAND(NUM_CAND), .SEL_W(SEL_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .target(target), .mask(mask), .sel(sel), .cand(cand),
        .busy(busy), .done(done), .match_found(match_found),
        .match_idx(match_idx), .match_count(match_count),
        .match_bitmap(match_bitmap)
    );

    // Candidate mux model
    always_comb cand = cand_tbl[sel];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sbq.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("done_cycle", 128'(cyc), 128'(e.cyc));
                chk("match_found", 128'(match_found), 128'(e.found));
                chk("match_idx", 128'(match_idx), 128'(e.idx));
                chk("match_count", 128'(match_count), 128'(e.cnt));
                chk("match_bitmap", 128'(match_bitmap), 128'(e.bmp));
                chk("busy_at_done", 128'(busy), 0);
            end
        end
    end

    // Called at a negedge: start is sampled on the following edge E0,
    // done is seen at the negedge after E17.
    task automatic push_exp(input logic f, input logic [3:0] i,
                            input logic [4:0] c, input logic [15:0] b);
        exp_t e;
        e.found = f;
        e.idx   = i;
        e.cnt   = c;
        e.bmp   = b;
        e.cyc   = cyc + 18;
        sbq.push_back(e);
        last_exp = e;
    endtask

    task automatic run_scan(input logic [WIDTH-1:0] t,
                            input logic [WIDTH-1:0] m,
                            input logic f, input logic [3:0] i,
                            input logic [4:0] c, input logic [15:0] b);
        @(negedge clk);
        target = t;
        mask   = m;
        push_exp(f, i, c, b);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int k = 0; k < 40 && sbq.size() != 0; k++) @(negedge clk);
        chk(tag, 128'(sbq.size()), 0);
    endtask

    initial begin
        cyc    = 0;
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        start  = 1'b0;
        target = '0;
        mask   = '0;
        for (int k = 0; k < NUM_CAND; k++) cand_tbl[k] = WIDTH'(k);

        repeat (2) @(negedge clk);
        chk("rst_sel", 128'(sel), 0);
        chk("rst_busy", 128'(busy), 0);
        chk("rst_done", 128'(done), 0);
        chk("rst_found", 128'(match_found), 0);
        chk("rst_count", 128'(match_count), 0);
        chk("rst_bitmap", 128'(match_bitmap), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1: exact match on index 5, with select walk checked
        @(negedge clk);
        target = 128'd5;
        mask   = ONES;
        push_exp(1'b1, 4'd5, 5'd1, 16'h0020);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < NUM_CAND; k++) begin
            chk($sformatf("sel_walk_%0d", k), 128'(sel), 128'(k));
            chk($sformatf("busy_%0d", k), 128'(busy), 1);
            @(negedge clk);
        end
        chk("sel_wrap", 128'(sel), 0);
        drain("drain_s1");
        repeat (3) @(negedge clk);
        chk("hold_idx", 128'(match_idx), 128'(last_exp.idx));
        chk("hold_bitmap", 128'(match_bitmap), 128'(last_exp.bmp));

        // 2: LSB-only mask picks all odd candidates
        run_scan(128'h1, 128'h1, 1'b1, 4'd1, 5'd8, 16'hAAAA);
        drain("drain_s2");

        // 3: no candidate matches
        run_scan(128'h100, ONES, 1'b0, 4'd0, 5'd0, 16'h0000);
        drain("drain_s3");

        // 4: empty mask matches everything, count must reach 16
        run_scan(128'hDEAD_BEEF, '0, 1'b1, 4'd0, 5'b10000, 16'hFFFF);
        drain("drain_s4");

        // 5: reset mid-scan discards everything, no done
        @(negedge clk);
        target = 128'd5;
        mask   = ONES;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        chk("pre_rst_busy", 128'(busy), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_sel", 128'(sel), 0);
        chk("arst_busy", 128'(busy), 0);
        chk("arst_found", 128'(match_found), 0);
        chk("arst_idx", 128'(match_idx), 0);
        chk("arst_count", 128'(match_count), 0);
        chk("arst_bitmap", 128'(match_bitmap), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("no_done_after_rst", 128'(done), 0);
        run_scan(128'd5, ONES, 1'b1, 4'd5, 5'd1, 16'h0020);
        drain("drain_s5");

        // 6: start held high, back-to-back scans, target changed mid-scan
        @(negedge clk);
        target = 128'd5;
        mask   = ONES;
        push_exp(1'b1, 4'd5, 5'd1, 16'h0020);
        start = 1'b1;
        repeat (8) @(negedge clk);
        target = 128'd7;
        repeat (10) @(negedge clk);
        chk("restart_done", 128'(done), 1);
        push_exp(1'b1, 4'd7, 5'd1, 16'h0080);
        repeat (18) @(negedge clk);
        start = 1'b0;
        drain("drain_s6");
        repeat (25) @(negedge clk);
        chk("idle_after_s6", 128'(busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
